// File: rtl/recip_sequencer.sv
// recip_sequencer: iterative single-precision reciprocal (Newton-Raphson on one shared multiplier and adder); define RECIP_ITER2_EN for 2 iterations instead of 3.
module fp_mul (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] out
);
  logic [47:0] prod;
  logic [9:0]  ex;
  logic [22:0] mant;
  logic        g, st;
  logic [30:0] mag;
  always_comb begin
    prod = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    ex   = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127 + {9'b0, prod[47]};
    mant = prod[47] ? prod[46:24] : prod[45:23];
    g    = prod[47] ? prod[23] : prod[22];
    st   = prod[47] ? |prod[22:0] : |prod[21:0];
    mag  = {ex[7:0], mant} + {30'b0, g & (st | mant[0])};
    out  = (a[30:23] == 8'd0 || b[30:23] == 8'd0 || ex[9] || ex == 10'd0) ? {a[31] ^ b[31], 31'b0} :
           (ex >= 10'd255) ? {a[31] ^ b[31], 8'hFF, 23'b0} : {a[31] ^ b[31], mag};
  end
endmodule

module fp_add (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] out
);
  logic [31:0] x, y;
  logic [26:0] mx, my, al, shl, nm;
  logic [53:0] sh;
  logic [7:0]  d;
  logic [4:0]  dc, lz;
  logic [27:0] sum;
  logic [9:0]  ex;
  logic [30:0] mag;
  always_comb begin
    x   = (a[30:0] >= b[30:0]) ? a : b;
    y   = (a[30:0] >= b[30:0]) ? b : a;
    mx  = {x[30:23] != 8'd0, x[22:0], 3'b0};
    my  = {y[30:23] != 8'd0, y[22:0], 3'b0};
    d   = x[30:23] - y[30:23];
    dc  = (d > 8'd30) ? 5'd30 : d[4:0];
    sh  = {my, 27'b0} >> dc;
    al  = {sh[53:28], sh[27] | (|sh[26:0])};
    sum = (x[31] ^ y[31]) ? {1'b0, mx} - {1'b0, al} : {1'b0, mx} + {1'b0, al};
    lz  = 5'd0;
    for (int i = 0; i < 27; i++)
      if (sum[i]) lz = 5'(26 - i);
    shl = sum[26:0] << lz;
    nm  = sum[27] ? {sum[27:2], sum[1] | sum[0]} : shl;
    ex  = sum[27] ? {2'b0, x[30:23]} + 10'd1 : {2'b0, x[30:23]} - {5'b0, lz};
    mag = {ex[7:0], nm[25:3]} + {30'b0, nm[2] & (nm[1] | nm[0] | nm[3])};
    // nm[26] is the normalised hidden bit; it is clear only for an exact-zero sum
    out = (!nm[26] || ex[9] || ex == 10'd0) ? {x[31] & nm[26], 31'b0} :
          (ex >= 10'd255) ? {x[31], 8'hFF, 23'b0} : {x[31], mag};
  end
endmodule

module recip_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);
`ifdef RECIP_ITER2_EN
  localparam logic [3:0] LAST = 4'd7;
`else
  localparam logic [3:0] LAST = 4'd10;
`endif
  localparam logic [31:0] C32 = 32'h3FF0F0F1;
  localparam logic [31:0] C48 = 32'h4034B4B5;
  localparam logic [31:0] TWO = 32'h40000000;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic        s, pend, special, accept, ph_dn, ph_sub, ph_nt;
  logic [7:0]  e;
  logic [31:0] d, t, n, mul_a, mul_b, mul_out, add_a, add_b, add_out, special_val, packed_res;
  logic [9:0]  ex;

  fp_mul u_mul (.a(mul_a), .b(mul_b), .out(mul_out));
  fp_add u_add (.a(add_a), .b(add_b), .out(add_out));

  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;

  // special operands spend one cycle in IDLE (pend) so they also report after one edge
  always_comb
    state_nx = (state == IDLE) ? (pend ? DONE : (in_valid ? (special ? IDLE : RUN) : IDLE)) :
               (state == RUN) ? ((cnt == LAST) ? DONE : RUN) :
               (out_ready ? IDLE : DONE);

  always_comb begin
    in_ready  = (state == IDLE) && !pend;
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  always_comb begin
    accept      = in_ready && in_valid;
    special     = (in_data[30:23] == 8'd0) || (in_data[30:23] == 8'hFF);
    special_val = (in_data[30:23] == 8'd0) ? {in_data[31], 8'hFF, 23'b0} :
                  (in_data[22:0] == 23'd0) ? {in_data[31], 31'b0} : 32'h7FC00000;
    ph_dn       = (cnt == 4'd2) || (cnt == 4'd5) || (cnt == 4'd8);
    ph_sub      = (cnt == 4'd3) || (cnt == 4'd6) || (cnt == 4'd9);
    ph_nt       = (cnt == 4'd4) || (cnt == 4'd7) || (cnt == 4'd10);
    mul_a       = (cnt == 4'd0) ? C32 : n;
    mul_b       = (cnt == 4'd0 || ph_dn) ? d : t;
    add_a       = (cnt == 4'd1) ? C48 : TWO;
    add_b       = {~t[31], t[30:0]};
    ex          = {2'b0, mul_out[30:23]} + 10'd126 - {2'b0, e};
    packed_res  = ($signed(ex) <= 10'sd0) ? {s, 31'b0} :
                  ($signed(ex) >= 10'sd255) ? {s, 8'hFF, 23'b0} : {s, ex[7:0], mul_out[22:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 4'd0;
      t        <= 32'd0;
      n        <= 32'd0;
      d        <= 32'd0;
      s        <= 1'b0;
      e        <= 8'd0;
      pend     <= 1'b0;
      out_data <= 32'd0;
    end else begin
      pend <= accept && special;
      if (accept) begin
        s   <= in_data[31];
        e   <= in_data[30:23];
        d   <= {1'b0, 8'h7E, in_data[22:0]};
        cnt <= 4'd0;
      end
      if (accept && special)
        out_data <= special_val;
      if (state == RUN) begin
        cnt <= cnt + 4'd1;
        t   <= (cnt == 4'd0 || ph_dn) ? mul_out : ph_sub ? add_out : t;
        n   <= (cnt == 4'd1) ? add_out : ph_nt ? mul_out : n;
        if (cnt == LAST)
          out_data <= packed_res;
      end
    end
  end
endmodule

// File: tb/tb_recip_sequencer.sv
// tb_recip_sequencer: directed checks of recip_sequencer results, latency, handshake and reset.
module tb_recip_sequencer;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] in_data, out_data, r, held;
  int          checks = 0;
  int          failures = 0;
`ifdef RECIP_ITER2_EN
  localparam int LAT = 8;
  localparam int TOL = 160;
`else
  localparam int LAT = 11;
  localparam int TOL = 4;
`endif

  always #5 clk = ~clk;

  recip_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_near(input string tag, input logic [31:0] got, input logic [31:0] exp, input int tol);
    int  df;
    logic ok;
    df = int'(got[30:0]) - int'(exp[30:0]);
    ok = (^got !== 1'bx) && (got[31] === exp[31]) && (df <= tol) && (df >= -tol);
    checks++;
    assert (ok) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h (+/-%0d ulp)", tag, got, exp, tol);
    end
  endtask

  task automatic xfer(input string tag, input logic [31:0] x, input int lat, output logic [31:0] res);
    int cyc;
    chk({tag, "_ready"}, {31'b0, in_ready}, 32'd1);
    in_data  = x;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_data  = $urandom;
    chk({tag, "_busy_in_ready"}, {31'b0, in_ready}, 32'd0);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      step();
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(lat));
    res = out_data;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_idle_after"}, {30'b0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = 32'd0;
    step();
    step();
    rst = 1'b0;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);

    xfer("two", 32'h40000000, LAT, r);
    chk_near("two_val", r, 32'h3F000000, TOL);
    xfer("neg5", 32'hC0A00000, LAT, r);
    chk_near("neg5_val", r, 32'hBE4CCCCD, TOL);
    chk("neg5_sign", {31'b0, r[31]}, 32'd1);
    xfer("three", 32'h40400000, LAT, r);
    chk_near("three_val", r, 32'h3EAAAAAB, TOL);
    xfer("ten", 32'h41200000, LAT, r);
    chk_near("ten_val", r, 32'h3DCCCCCD, TOL);
    xfer("minnorm", 32'h00800000, LAT, r);
    chk_near("minnorm_val", r, 32'h7E800000, TOL);
    xfer("big", 32'h7F000000, LAT, r);
    chk("big_flush", r, 32'h00000000);

    xfer("zero", 32'h00000000, 1, r);
    chk("zero_val", r, 32'h7F800000);
    xfer("negzero", 32'h80000000, 1, r);
    chk("negzero_val", r, 32'hFF800000);
    xfer("denorm", 32'h00000001, 1, r);
    chk("denorm_val", r, 32'h7F800000);
    xfer("inf", 32'h7F800000, 1, r);
    chk("inf_val", r, 32'h00000000);
    xfer("neginf", 32'hFF800000, 1, r);
    chk("neginf_val", r, 32'h80000000);
    xfer("nan", 32'h7FC00001, 1, r);
    chk("nan_val", r, 32'h7FC00000);

    // back-pressure: result must hold while out_ready stays low
    in_data = 32'h40800000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 40 && out_valid !== 1'b1; i++) step();
    chk("hold_valid", {31'b0, out_valid}, 32'd1);
    held = out_data;
    chk_near("hold_val", held, 32'h3E800000, TOL);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h3F800000 + 32'(i);
      step();
      chk("hold_stable", out_data, held);
      chk("hold_in_ready", {30'b0, in_ready, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("release_idle", {29'b0, in_ready, out_valid, busy}, 32'd4);
    in_valid = 1'b0;
    step();
    chk("release_no_accept", {31'b0, busy}, 32'd0);

    // reset in the middle of RUN discards the operation
    in_data = 32'h3F800000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("midrun_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    out_ready = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b0;
    chk("midrun_rst", {29'b0, in_ready, out_valid, busy}, 32'd4);
    chk("midrun_rst_data", out_data, 32'd0);
    for (int i = 0; i < 14; i++) step();
    chk("midrun_no_result", {31'b0, out_valid}, 32'd0);
    xfer("one", 32'h3F800000, LAT, r);
    chk_near("one_val", r, 32'h3F800000, TOL);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/recip_sequencer.md
RECIP_SEQUENCER -- requirements
Module: recip_sequencer

Interface
REQ-001 The block SHALL have no parameters; its only build-time option is the macro in REQ-030.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  operand x available on in_data.
REQ-005 in_ready  output  1  block accepts an operand this cycle.
REQ-006 in_data  input  32  IEEE-754 single-precision operand x.
REQ-007 out_valid  output  1  result held on out_data.
REQ-008 out_ready  input  1  consumer takes the result this cycle.
REQ-009 out_data  output  32  single-precision approximation of 1/x.
REQ-010 busy  output  1  high whenever the block is not in IDLE.

Function
REQ-011 Arithmetic resources SHALL be exactly one instance each of the codebase's combinational single-precision multiplier and adder (ports a, b, out), time-shared across all steps.
REQ-012 States SHALL be IDLE, RUN and DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-013 Acceptance: in IDLE with in_valid = 1, on the clock edge the block SHALL register the sign s, the exponent e and the scaled mantissa D = {0, 8'h7E, in_data[22:0]}, where D lies in [0.5, 1).
REQ-014 On acceptance the block SHALL go to RUN with step counter = 0, unless a special case applies (REQ-019).
REQ-015 RUN SHALL issue one operation per cycle on the shared units and latch that operation's output into temp register T or N.
REQ-016 Step sequence:
- step 0: T = 32/17 * D
- step 1: N = 48/17 - T (N0)
- then, per iteration: T = D * N; T = 2.0 - T; N = N * T
- subtraction is done by inverting the sign bit of the adder's b operand.
REQ-017 The default build SHALL run 3 iterations (11 steps, counter 0..10); after the last step's edge the block SHALL go to DONE.
REQ-018 In DONE, out_data SHALL be {s, E, N[22:0]} with E = N[30:23] + 126 - e, computed at 10 bits signed:
- E <= 0: out_data = {s, 31'b0}
- E >= 255: out_data = {s, 8'hFF, 23'b0}.
REQ-019 Special cases SHALL bypass RUN and go straight to DONE one edge after acceptance:
- e = 0 (zero/denormal): {s, 8'hFF, 0}
- e = 255 with mantissa 0: {s, 31'b0}
- NaN input: 32'h7FC00000.
REQ-020 DONE SHALL hold out_data stable until out_valid & out_ready; on that edge it SHALL go to IDLE; an input is not accepted in that same cycle.
REQ-021 Latency from the acceptance edge to out_valid: 11 edges by default, 8 with REQ-030, 1 for special cases.
REQ-022 Throughput: one result per latency + 2 cycles at most.
REQ-023 Input changes during RUN or DONE SHALL have no effect.

Reset
REQ-024 rst = 1 on an edge SHALL force IDLE, counter = 0, T = N = 0, and out_data = 0.
REQ-025 Outputs after reset: in_ready = 1, out_valid = 0, busy = 0.
REQ-026 Reset asserted mid-RUN or in DONE SHALL discard the operation with no result produced.
REQ-027 Reset SHALL take priority over every concurrent handshake.

Configuration
REQ-030 With RECIP_ITER2_EN defined the block SHALL run 2 iterations (8 steps); the relative error bound becomes 2^-16.
REQ-031 Without RECIP_ITER2_EN the block SHALL run 3 iterations; the error SHALL be within 4 ULP of the exact reciprocal.

Verification
REQ-040 in_data = 32'h40000000 (2.0), out_ready = 1 -> out_valid 11 edges after acceptance; out_data within 4 ULP of 32'h3F000000.
REQ-041 in_data = 32'hC0A00000 (-5.0) -> out_data within 4 ULP of 32'hBE4CCCCD; sign bit = 1.
REQ-042 in_data = 32'h00000000, then 32'h7F800000, then 32'h7FC00001 -> outputs 32'h7F800000, 32'h00000000 and 32'h7FC00000 respectively, each 1 edge after acceptance.
REQ-043 out_ready held 0 for 5 cycles in DONE -> out_data stable, in_ready = 0 throughout; releasing out_ready gives IDLE on the next edge.
REQ-044 rst pulsed at RUN step 4 -> next cycle in_ready = 1, out_valid = 0; a following 1.0 input yields a result within 4 ULP of 32'h3F800000.
REQ-045 in_data = 32'h7F000000 (about 1.7e38) -> out_data = 32'h00000000 (underflow flush).
